// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions (state encoding, default bit period, frame-length helper).
// Latency: n/a (types and constants only).
// Backpressure: n/a. Used by both the transmitter and the receiver.
package uart_pkg;

  // FSM state encoding shared by the TX and RX sides
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // 100 MHz / 115200 baud
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;

`ifdef UART_TX_PARITY_EN
  localparam int unsigned PARITY_BITS = 1;
`else
  localparam int unsigned PARITY_BITS = 0;
`endif

  // Bits on the line per frame: start + 8 data + optional parity + stop bits
  function automatic int unsigned frame_bits(input int unsigned stop_bits);
    return 9 + PARITY_BITS + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_core_if.sv
// uart_tx_core_if: byte handshake between the loopback FSM (master) and the UART TX core (slave).
// Latency: n/a (wires only).
// Backpressure: master may only hand over a byte in a cycle where tx_ready is high.
// Signals: tx_dv/tx_byte (master->core), tx_ready/tx_busy/tx_done (core->master).
interface uart_tx_core_if;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    output tx_dv,
    output tx_byte,
    input  tx_ready,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  tx_dv,
    input  tx_byte,
    output tx_ready,
    output tx_busy,
    output tx_done
  );
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running bit-period counter, bit_tick_o high on the last cycle of each bit.
// Latency: tick CLKS_PER_BIT cycles after a clear.
// Backpressure: none; clr_i restarts the period so bit boundaries align to frame start.
// Ports: clk, rst_n, clr_i (sync clear), bit_tick_o.
module uart_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic bit_tick_o
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign bit_tick_o = (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr_i || bit_tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_core.sv
// uart_tx_core: 8N1 UART transmitter with a one-byte holding register (optional parity: UART_TX_PARITY_EN).
// Latency: tx_serial falls 2 edges after the accepting edge from idle; frames back-to-back with no gap.
// Backpressure: tx_ready low while the holding register is full; tx_dv in that state is dropped.
// Ports: clk, rst_n, tx_if (slave: tx_dv/tx_byte in, tx_ready/tx_busy/tx_done out), tx_serial (line, idles high).
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_tx_core_if.slave  tx_if,
  output logic           tx_serial
);

  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  uart_state_e state_q, state_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_vld_q, hold_vld_d;
  logic [7:0]  data_q, data_d;
  logic [2:0]  idx_q, idx_d;
  logic        ser_q;
  logic        done_pend_q;
  logic        done_q;

  logic        bit_tick;
  logic        load;
  logic        stop_end;
  logic        line;
  logic        accept;

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (load),
    .bit_tick_o (bit_tick)
  );

  assign accept         = tx_if.tx_dv && !hold_vld_q;
  assign tx_if.tx_ready = !hold_vld_q;
  assign tx_if.tx_busy  = (state_q != ST_IDLE);
  assign tx_if.tx_done  = done_q;
  assign tx_serial      = ser_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    data_d   = data_q;
    load     = 1'b0;
    stop_end = 1'b0;
    line     = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (hold_vld_q) begin
          state_d = ST_START;
          load    = 1'b1;
        end
      end
      ST_START: begin
        line = 1'b0;
        if (bit_tick) begin
          state_d = ST_DATA;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        line = data_q[idx_q];
        if (bit_tick) begin
          if (idx_q == 3'd7) begin
            idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        // Only reachable when parity is compiled in
        line = (^data_q) ^ (PARITY_ODD != 0);
        if (bit_tick) begin
          state_d = ST_STOP;
          idx_d   = '0;
        end
      end
      ST_STOP: begin
        if (bit_tick) begin
          if (idx_q == STOP_LAST) begin
            stop_end = 1'b1;
            idx_d    = '0;
            // A byte already waiting starts its frame with no idle bit in between
            if (hold_vld_q) begin
              state_d = ST_START;
              load    = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (load) begin
      data_d = hold_q;
    end
  end

  // load and accept are exclusive: load needs a full holding register, accept an empty one
  always_comb begin
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    if (load) begin
      hold_vld_d = 1'b0;
    end
    if (accept) begin
      hold_d     = tx_if.tx_byte;
      hold_vld_d = 1'b1;
    end
  end

  // The line is driven from the current state, so it trails state entry by one edge.
  // tx_done gets one more stage so it rises as the last stop bit finishes on the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      data_q      <= '0;
      idx_q       <= '0;
      ser_q       <= 1'b1;
      done_pend_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      data_q      <= data_d;
      idx_q       <= idx_d;
      ser_q       <= line;
      done_pend_q <= stop_end;
      done_q      <= done_pend_q;
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core: directed bench for uart_tx_core (CLKS_PER_BIT=4; STOP_BITS=1 and a STOP_BITS=2 instance).
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_tx_core;
  import uart_pkg::*;

  logic clk;
  logic rst_n;
  logic ser1;
  logic ser2;
  int   checks;
  int   errors;
  bit   use2;

  uart_tx_core_if if1();
  uart_tx_core_if if2();

  uart_tx_core #(.CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY_ODD(0)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_if     (if1),
    .tx_serial (ser1)
  );

  uart_tx_core #(.CLKS_PER_BIT(4), .STOP_BITS(2), .PARITY_ODD(0)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_if     (if2),
    .tx_serial (ser2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic cur_ser();
    return use2 ? ser2 : ser1;
  endfunction
  function automatic logic cur_done();
    return use2 ? if2.tx_done : if1.tx_done;
  endfunction
  function automatic logic cur_rdy();
    return use2 ? if2.tx_ready : if1.tx_ready;
  endfunction
  function automatic logic cur_busy();
    return use2 ? if2.tx_busy : if1.tx_busy;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic dv, input logic [7:0] b);
    if (use2) begin
      if2.tx_dv   = dv;
      if2.tx_byte = b;
    end else begin
      if1.tx_dv   = dv;
      if1.tx_byte = b;
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Called on the negedge k0 cycles after the start bit appeared on the line.
  // Checks every cycle of the frame, returns on the negedge where the frame has ended.
  task automatic frame_check(input logic [7:0] b, input int stop_bits, input string tag, input int k0);
    int   nb;
    int   bi;
    logic exp;
    nb = int'(frame_bits(stop_bits));
    for (int k = k0; k < nb * 4; k++) begin
      bi = k / 4;
      if (bi == 0)                              exp = 1'b0;
      else if (bi <= 8)                         exp = b[bi-1];
      else if (PARITY_BITS == 1 && bi == 9)     exp = ^b;
      else                                      exp = 1'b1;
      chk({tag, "_ser"}, cur_ser(), exp);
      if (k != 0) chk({tag, "_done_lo"}, cur_done(), 1'b0);
      @(negedge clk);
    end
    chk({tag, "_done_pulse"}, cur_done(), 1'b1);
  endtask

  // Hand over one byte from idle and check latency up to the start bit
  task automatic send_from_idle(input logic [7:0] b, input string tag);
    chk({tag, "_rdy_idle"}, cur_rdy(), 1'b1);
    drive(1'b1, b);
    @(negedge clk);                        // accepting edge passed
    drive(1'b0, 8'h00);
    chk({tag, "_rdy_full"}, cur_rdy(), 1'b0);
    chk({tag, "_ser_e0"}, cur_ser(), 1'b1);
    @(negedge clk);                        // transfer edge passed
    chk({tag, "_busy"}, cur_busy(), 1'b1);
    chk({tag, "_ser_e1"}, cur_ser(), 1'b1);
    chk({tag, "_rdy_back"}, cur_rdy(), 1'b1);
    @(negedge clk);                        // line falls on this edge
  endtask

  initial begin
    checks = 0;
    errors = 0;
    use2   = 1'b0;
    rst_n  = 1'b0;
    if1.tx_dv = 1'b0; if1.tx_byte = 8'h00;
    if2.tx_dv = 1'b0; if2.tx_byte = 8'h00;

    // Reset state
    cyc(3);
    chk("rst_ser", ser1, 1'b1);
    chk("rst_rdy", if1.tx_ready, 1'b1);
    chk("rst_busy", if1.tx_busy, 1'b0);
    chk("rst_done", if1.tx_done, 1'b0);
    chk("rst_ser2", ser2, 1'b1);
    rst_n = 1'b1;
    cyc(3);
    chk("idle_ser", ser1, 1'b1);

    // Single byte 0xA5 from idle
    send_from_idle(8'hA5, "a5");
    frame_check(8'hA5, 1, "a5", 0);
    chk("a5_ser_idle", ser1, 1'b1);
    chk("a5_busy_end", if1.tx_busy, 1'b0);
    @(negedge clk);
    chk("a5_done_once", if1.tx_done, 1'b0);
    cyc(3);

    // Back-to-back 0x00 then 0xFF; a byte offered on the transfer cycle is ignored
    drive(1'b1, 8'h00);
    @(negedge clk);
    chk("b2b_rdy_xfer", if1.tx_ready, 1'b0);
    drive(1'b1, 8'h55);
    @(negedge clk);
    chk("b2b_rdy_after", if1.tx_ready, 1'b1);
    drive(1'b1, 8'hFF);
    @(negedge clk);
    drive(1'b0, 8'h00);
    chk("b2b_rdy_held", if1.tx_ready, 1'b0);
    frame_check(8'h00, 1, "b2b0", 0);
    chk("b2b_nogap", ser1, 1'b0);
    frame_check(8'hFF, 1, "b2b1", 0);
    chk("b2b_idle", ser1, 1'b1);
    cyc(3);

    // Overflow: third byte offered while the holding register is full is dropped
    drive(1'b1, 8'h12);
    @(negedge clk);
    drive(1'b0, 8'h00);
    @(negedge clk);
    chk("ovf_rdy1", if1.tx_ready, 1'b1);
    drive(1'b1, 8'h34);
    @(negedge clk);
    drive(1'b0, 8'h00);
    chk("ovf_rdy2", if1.tx_ready, 1'b0);
    @(negedge clk);
    drive(1'b1, 8'h56);
    chk("ovf_rdy3", if1.tx_ready, 1'b0);
    @(negedge clk);
    drive(1'b0, 8'h00);
    frame_check(8'h12, 1, "ovf0", 2);
    chk("ovf_nogap", ser1, 1'b0);
    frame_check(8'h34, 1, "ovf1", 0);
    for (int i = 0; i < 12; i++) begin
      chk("ovf_no3rd_ser", ser1, 1'b1);
      chk("ovf_no3rd_busy", if1.tx_busy, 1'b0);
      @(negedge clk);
    end

`ifdef UART_TX_PARITY_EN
    // Even parity of 0x07 is 1; 11-bit frame
    send_from_idle(8'h07, "par");
    frame_check(8'h07, 1, "par", 0);
    chk("par_idle", ser1, 1'b1);
    cyc(3);
`endif

    // Two stop bits on the second instance
    use2 = 1'b1;
    send_from_idle(8'h3C, "stp2");
    frame_check(8'h3C, 2, "stp2", 0);
    chk("stp2_idle", ser2, 1'b1);
    chk("stp2_busy", if2.tx_busy, 1'b0);
    use2 = 1'b0;
    cyc(3);

    // Reset mid-frame: 0x0F, bit 4 (low) is on the line 20 cycles in
    send_from_idle(8'h0F, "mrst");
    cyc(20);
    chk("mrst_pre_ser", ser1, 1'b0);
    chk("mrst_pre_busy", if1.tx_busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_ser", ser1, 1'b1);
    chk("mrst_rdy", if1.tx_ready, 1'b1);
    chk("mrst_busy", if1.tx_busy, 1'b0);
    chk("mrst_done", if1.tx_done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mrst_after_ser", ser1, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
